// File: rtl/fetch_prefetch_unit.sv
// Instruction prefetch queue. It issues in-order fetches, buffers the returned
// words for decode, and on a redirect flushes the queue and discards stale responses.
module fetch_prefetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 4
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output logic        out_valid,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  input  logic        out_ready,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc
);

  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  // Stale responses can pile up across back-to-back redirects; this leaves headroom
  // for sixteen queues' worth of in-flight requests.
  localparam int DROP_W = PTR_W + 4;

  localparam logic [PTR_W-1:0]  PTR_ONE  = PTR_W'(1);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(DEPTH);
  localparam logic [DROP_W-1:0] DROP_ONE = DROP_W'(1);

  logic [31:0]       fetch_pc_q, fetch_pc_d;
  logic [PTR_W-1:0]  head_q, head_d;
  logic [PTR_W-1:0]  tail_q, tail_d;
  logic [PTR_W-1:0]  fill_ptr_q, fill_ptr_d;
  logic [CNT_W-1:0]  reserved_q, reserved_d;
  logic [CNT_W-1:0]  pending_q, pending_d;
  logic [DROP_W-1:0] drop_cnt_q, drop_cnt_d;
  logic [DROP_W-1:0] unanswered;

  logic [31:0]      pc_q    [DEPTH];
  logic [31:0]      instr_q [DEPTH];
  logic [DEPTH-1:0] filled_q;

  logic req_fire, deq_fire, fill_en;

  // Request valid depends only on registered occupancy, never on out_ready.
  assign imem_req_valid = rst && (reserved_q < CNT_FULL) && !redirect_valid;
  assign imem_req_addr  = fetch_pc_q;
  assign out_valid      = filled_q[head_q];
  assign out_instr      = instr_q[head_q];
  assign out_pc         = pc_q[head_q];

  assign req_fire   = imem_req_valid && imem_req_ready;
  assign deq_fire   = out_valid && out_ready;
  assign fill_en    = imem_resp_valid && !redirect_valid &&
                      (drop_cnt_q == '0) && (pending_q != '0);
  assign unanswered = drop_cnt_q + DROP_W'(pending_q);

  // NOTE: every next-state signal takes its current value first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    head_d     = head_q;
    tail_d     = tail_q;
    fill_ptr_d = fill_ptr_q;
    reserved_d = reserved_q;
    pending_d  = pending_q;
    drop_cnt_d = drop_cnt_q;
    if (redirect_valid) begin
      fetch_pc_d = redirect_pc & ~32'd3;
      head_d     = '0;
      tail_d     = '0;
      fill_ptr_d = '0;
      reserved_d = '0;
      pending_d  = '0;
      // A response landing on the redirect edge is answered and thrown away.
      drop_cnt_d = (imem_resp_valid && (unanswered != '0)) ? unanswered - DROP_ONE
                                                           : unanswered;
    end else begin
      if (req_fire) begin
        fetch_pc_d = fetch_pc_q + 32'd4;
        tail_d     = tail_q + PTR_ONE;
      end
      if (deq_fire) head_d = head_q + PTR_ONE;
      if (fill_en)  fill_ptr_d = fill_ptr_q + PTR_ONE;
      if (imem_resp_valid && (drop_cnt_q != '0)) drop_cnt_d = drop_cnt_q - DROP_ONE;
      case ({req_fire, deq_fire})
        2'b10:   reserved_d = reserved_q + CNT_ONE;
        2'b01:   reserved_d = reserved_q - CNT_ONE;
        default: reserved_d = reserved_q;
      endcase
      case ({req_fire, fill_en})
        2'b10:   pending_d = pending_q + CNT_ONE;
        2'b01:   pending_d = pending_q - CNT_ONE;
        default: pending_d = pending_q;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc_q <= RESET_PC;
      head_q     <= '0;
      tail_q     <= '0;
      fill_ptr_q <= '0;
      reserved_q <= '0;
      pending_q  <= '0;
      drop_cnt_q <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      fill_ptr_q <= fill_ptr_d;
      reserved_q <= reserved_d;
      pending_q  <= pending_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  // NOTE: the entry storage is reset on purpose, because the head entry drives out_pc/out_instr and those must read zero in reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      filled_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        pc_q[i]    <= '0;
        instr_q[i] <= '0;
      end
    end else if (redirect_valid) begin
      filled_q <= '0;
    end else begin
      if (deq_fire) filled_q[head_q] <= 1'b0;
      if (req_fire) begin
        pc_q[tail_q]     <= fetch_pc_q;
        filled_q[tail_q] <= 1'b0;
      end
      if (fill_en) begin
        instr_q[fill_ptr_q]  <= imem_resp_data;
        filled_q[fill_ptr_q] <= 1'b1;
      end
    end
  end

endmodule
